// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 ECB decryptor: a word of NUM_BLOCKS blocks, one block at a
// time, one round per clock. Round keys are fetched from an external store via
// rk_idx; no key expansion happens here.
module aes_decrypt_core #(
  parameter int NUM_BLOCKS = 8,
  parameter int DATA_W     = 128*NUM_BLOCKS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ct_in,
  output logic [3:0]        rk_idx,
  input  logic [127:0]      rk_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pt_out,
  output logic              busy
);
  localparam int CNT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] ct_q, pt_buf_q, pt_out_q, pt_buf_d;
  logic [127:0]      st_q, st_init_d, st_round_d, blk_last_d;
  logic [CNT_W-1:0]  blk_cnt_q;
  logic [3:0]        rnd_q;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i (FIPS-197 order) lives at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a, x2, x4, x8;
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a  = s[127-8*(4*c+r) -: 8];
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        m9[r] = x8 ^ a;
        mb[r] = x8 ^ x2 ^ a;
        md[r] = x8 ^ x4 ^ a;
        me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction

  // Status outputs decode directly from the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_INIT) || (state_q == S_ROUND);
  assign pt_out    = pt_out_q;

  // Round-key request: 10 for the initial AddRoundKey, the round counter otherwise.
  always_comb begin
    rk_idx = 4'd0;
    case (state_q)
      S_INIT:  rk_idx = 4'd10;
      S_ROUND: rk_idx = rnd_q;
      default: rk_idx = 4'd0;
    endcase
  end

  // Round datapath; the final round skips InvMixColumns and merges into the word.
  always_comb begin
    st_init_d  = ct_q[128*blk_cnt_q +: 128] ^ rk_data;
    blk_last_d = inv_shift_sub(st_q) ^ rk_data;
    st_round_d = inv_mix_columns(blk_last_d);
    pt_buf_d   = pt_buf_q;
    pt_buf_d[128*blk_cnt_q +: 128] = blk_last_d;
  end

  // Control FSM: accept, per-block init + 10 rounds, then hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ct_q      <= '0;
      pt_buf_q  <= '0;
      pt_out_q  <= '0;
      st_q      <= '0;
      blk_cnt_q <= '0;
      rnd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ct_q      <= ct_in;
          blk_cnt_q <= '0;
          state_q   <= S_INIT;
        end
        S_INIT: begin
          st_q    <= st_init_d;
          rnd_q   <= 4'd9;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (rnd_q != 4'd0) begin
            st_q  <= st_round_d;
            rnd_q <= rnd_q - 4'd1;
          end else begin
            pt_buf_q <= pt_buf_d;
            if (blk_cnt_q == CNT_W'(NUM_BLOCKS-1)) begin
              // Only a completed word ever reaches the output register.
              pt_out_q <= pt_buf_d;
              state_q  <= S_DONE;
            end else begin
              blk_cnt_q <= blk_cnt_q + 1'b1;
              state_q   <= S_INIT;
            end
          end
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
